main_mem_ctrl: RTL and testbench
================================

// Module: main_mem_ctrl
// PURPOSE
//  Byte-serial main-memory controller directly downstream of the 2-way cache controller. Serves its
//  block refills (4-byte read bursts on data_mem) and dirty-block write-backs (4 beats numbered on wr_mem).
//  Holds a 2**AWIDTH x DWIDTH storage array. Uses ready_mem as the single busy/idle handshake back to the cache.
// PARAMETERS
//  AWIDTH      9  byte address width; array depth = 2**AWIDTH
//  DWIDTH      8  data byte width
//  BLOCKSIZE   4  bytes per cache block (burst length); low log2(BLOCKSIZE) address bits ignored
//  RD_LATENCY  2  idle cycles between read accept and first data byte (>=1)
//  WR_LATENCY  2  cycles from last write beat to array commit / ready (>=1)
// PORTS
//  clock      in     1       clock, all logic on rising edge
//  reset_n    in     1       asynchronous, active-low reset
//  addr_mem   in     AWIDTH  block address from cache; sampled only on request accept
//  rd_mem     in     1       block read request
//  wr_mem     in     4       write beat number: 0 = no beat, 1..BLOCKSIZE = beat index
//  wmem_byte  in     DWIDTH  write data for the current beat
//  data_mem   inout  DWIDTH  read data; driven only while rd_valid=1, else high-Z
//  ready_mem  out    1       1 = idle and can accept a request
//  rd_valid   out    1       1 = data_mem carries a valid read byte this cycle
//  err        out    1       sticky protocol-error flag
// BEHAVIOUR
//  Reset (async): state IDLE, ready_mem=1, rd_valid=0, data_mem=Z, err=0, beat counter=0.
//   Array contents are not cleared by reset. An in-flight write is discarded; an in-flight read is aborted.
//  base = {addr_mem[AWIDTH-1:2],2'b00}, latched on accept. Burst bytes are base+0..base+3, with no carry out of the block.
//  FSM states: IDLE, RD_WAIT, RD_BURST, WR_COLLECT, WR_COMMIT.
//  IDLE: ready_mem=1.
//   - wr_mem==1 at edge T: accept write. Capture wmem_byte as byte0, latch base.
//     ready_mem=0 from T+1 -> WR_COLLECT.
//   - else rd_mem==1 at edge T: accept read, latch base, ready_mem=0 from T+1 -> RD_WAIT.
//   - wr_mem in 2..15 in IDLE: err=1, ignored.
//   - rd_mem=1 and wr_mem==1 together: the write is accepted, the read is dropped, and err=1.
//  RD_WAIT: RD_LATENCY cycles (T+1..T+RD_LATENCY), data_mem=Z, then RD_BURST.
//  RD_BURST: BLOCKSIZE consecutive cycles, byte k (k=0..3) in cycle T+RD_LATENCY+1+k.
//   In each such cycle rd_valid=1 and data_mem=mem[base+k], driven from a register.
//   In cycle T+RD_LATENCY+5: rd_valid=0, data_mem=Z, ready_mem=1, state IDLE.
//  WR_COLLECT: expects beats 2,3,4 in order, each capturing wmem_byte into byte (beat-1).
//   - wr_mem==0: wait and hold, no timeout.
//   - wr_mem == expected beat: capture the byte, expected+1.
//   - any other nonzero value: discard the whole block, err=1, return to IDLE (ready_mem=1 next cycle).
//   - After beat 4 is captured, go to WR_COMMIT.
//  WR_COMMIT: WR_LATENCY cycles. On the last edge, all 4 bytes are written to the array in one cycle.
//   ready_mem=1 in the following cycle. A read accepted afterwards returns the new data.
//  rd_mem or wr_mem while ready_mem=0 (outside the WR_COLLECT beats) is ignored, with no err.
//   rd_mem held high through completion re-triggers a new read on the first IDLE edge.
//  err clears only on reset. rd_valid and ready_mem are never both 1.
// TESTING
//  1 Reset mid-read: during RD_BURST byte1 assert reset_n=0 ->
//    rd_valid=0, data_mem=Z, ready_mem=1 immediately; array intact.
//  2 Write 0x104 with beats 1..4 = AA,BB,CC,DD, then read 0x106 ->
//    after RD_LATENCY cycles data_mem = AA,BB,CC,DD on 4 consecutive rd_valid cycles.
//  3 Write beats with wr_mem=0 gaps (1,0,2,0,0,3,4) ->
//    block committed correctly, err=0, ready_mem low until WR_LATENCY after beat 4.
//  4 Out-of-order beats 1,3 -> err=1, ready_mem=1 next cycle, target block unchanged on readback.
//  5 rd_mem=1 and wr_mem=1 in the same IDLE cycle -> write proceeds, no read burst, err=1.
//  6 Top block: write to and read from 0x1FF -> bytes at 0x1FC..0x1FF, no wrap into 0x000.

Source files
------------

// File: rtl/main_mem_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : main_mem_ctrl_if                                             |
// | Description : Cache-to-main-memory request/response bundle.                |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface main_mem_ctrl_if #(
    parameter int AWIDTH = 9,
    parameter int DWIDTH = 8
);
    logic [AWIDTH-1:0] addr_mem;
    logic              rd_mem;
    logic [3:0]        wr_mem;
    logic [DWIDTH-1:0] wmem_byte;
    logic              ready_mem;
    logic              rd_valid;
    logic              err;

    modport master (
        output addr_mem, rd_mem, wr_mem, wmem_byte,
        input  ready_mem, rd_valid, err
    );

    modport slave (
        input  addr_mem, rd_mem, wr_mem, wmem_byte,
        output ready_mem, rd_valid, err
    );
endinterface
`default_nettype wire

// File: rtl/main_mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : main_mem_ctrl                                                |
// | Description : Byte-serial main memory serving cache block refills/evicts.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module main_mem_ctrl #(
    parameter int AWIDTH     = 9,
    parameter int DWIDTH     = 8,
    parameter int BLOCKSIZE  = 4,
    parameter int RD_LATENCY = 2,
    parameter int WR_LATENCY = 2
) (
    input  wire logic        clock,
    input  wire logic        reset_n,
    inout  wire [DWIDTH-1:0] data_mem,
    main_mem_ctrl_if.slave   bus
);
    localparam int         c_OFS_W      = $clog2(BLOCKSIZE);
    localparam int         c_BLK_W      = AWIDTH - c_OFS_W;
    localparam logic [7:0] c_RD_LAST    = 8'(RD_LATENCY - 1);
    localparam logic [7:0] c_WR_LAST    = 8'(WR_LATENCY - 1);
    localparam logic [7:0] c_BURST_LAST = 8'(BLOCKSIZE - 1);
    localparam logic [3:0] c_LAST_BEAT  = 4'(BLOCKSIZE);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_RD_WAIT    = 3'd1,
        S_RD_BURST   = 3'd2,
        S_WR_COLLECT = 3'd3,
        S_WR_COMMIT  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_BLK_W-1:0]  r_blk;
    logic [7:0]          r_cnt;
    logic [3:0]          r_beat;
    logic [DWIDTH-1:0]   r_wbuf [BLOCKSIZE];
    logic [DWIDTH-1:0]   r_rd_data;
    logic                r_err;
    logic [DWIDTH-1:0]   r_mem [2**AWIDTH];

    logic                w_rd_accept;
    logic                w_wr_accept;
    logic                w_beat_ok;
    logic                w_commit;
    logic                w_proto_err;
    logic                w_rd_valid;
    logic [c_OFS_W-1:0]  w_burst_idx;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd_accept = 1'b0;
        w_wr_accept = 1'b0;
        w_beat_ok   = 1'b0;
        w_commit    = 1'b0;
        w_proto_err = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.wr_mem == 4'd1) begin
                    // A simultaneous read is dropped in favour of the write-back
                    w_wr_accept = 1'b1;
                    w_proto_err = bus.rd_mem;
                    w_state_nxt = S_WR_COLLECT;
                end else if (bus.wr_mem != 4'd0) begin
                    w_proto_err = 1'b1;
                end else if (bus.rd_mem) begin
                    w_rd_accept = 1'b1;
                    w_state_nxt = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (r_cnt == c_RD_LAST) begin
                    w_state_nxt = S_RD_BURST;
                end
            end
            S_RD_BURST: begin
                if (r_cnt == c_BURST_LAST) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WR_COLLECT: begin
                if (bus.wr_mem == r_beat) begin
                    w_beat_ok = 1'b1;
                    if (r_beat == c_LAST_BEAT) begin
                        w_state_nxt = S_WR_COMMIT;
                    end
                end else if (bus.wr_mem != 4'd0) begin
                    w_proto_err = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_WR_COMMIT: begin
                if (r_cnt == c_WR_LAST) begin
                    w_commit    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // First burst byte is fetched on the RD_WAIT exit edge, the rest one ahead
    assign w_burst_idx = (r_state == S_RD_BURST) ? c_OFS_W'(r_cnt + 8'd1) : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_blk     <= '0;
            r_cnt     <= '0;
            r_beat    <= '0;
            r_rd_data <= '0;
            r_err     <= 1'b0;
            for (int k = 0; k < BLOCKSIZE; k++) begin
                r_wbuf[k] <= '0;
            end
        end else begin
            r_cnt <= (w_state_nxt != r_state) ? 8'd0 : r_cnt + 8'd1;
            if (w_rd_accept || w_wr_accept) begin
                r_blk <= bus.addr_mem[AWIDTH-1:c_OFS_W];
            end
            if (w_wr_accept) begin
                r_wbuf[0] <= bus.wmem_byte;
                r_beat    <= 4'd2;
            end
            if (w_beat_ok) begin
                r_wbuf[c_OFS_W'(r_beat - 4'd1)] <= bus.wmem_byte;
                r_beat                          <= r_beat + 4'd1;
            end
            if (w_state_nxt == S_RD_BURST) begin
                r_rd_data <= r_mem[{r_blk, w_burst_idx}];
            end
            if (w_proto_err) begin
                r_err <= 1'b1;
            end
        end
    end

    // Storage array deliberately has no reset
    always_ff @(posedge clock) begin
        if (w_commit) begin
            for (int k = 0; k < BLOCKSIZE; k++) begin
                r_mem[{r_blk, c_OFS_W'(k)}] <= r_wbuf[k];
            end
        end
    end

    assign w_rd_valid    = (r_state == S_RD_BURST);
    assign bus.rd_valid  = w_rd_valid;
    assign bus.ready_mem = (r_state == S_IDLE);
    assign bus.err       = r_err;
    assign data_mem      = w_rd_valid ? r_rd_data : {DWIDTH{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_main_mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_main_mem_ctrl                                             |
// | Description : Directed self-checking bench for main_mem_ctrl.              |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_main_mem_ctrl;
    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    wire  [7:0] data_mem;
    int         checks   = 0;
    int         failures = 0;

    main_mem_ctrl_if #(.AWIDTH(9), .DWIDTH(8)) bus ();

    main_mem_ctrl #(
        .AWIDTH(9), .DWIDTH(8), .BLOCKSIZE(4), .RD_LATENCY(2), .WR_LATENCY(2)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .data_mem(data_mem),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wr_beat(input logic [3:0] b, input logic [7:0] d);
        bus.wr_mem    = b;
        bus.wmem_byte = d;
        step();
        bus.wr_mem    = 4'd0;
    endtask

    // w packs bytes as {byte0, byte1, byte2, byte3}
    task automatic write_block(input logic [8:0] a, input logic [31:0] w, input string tag);
        bus.addr_mem = a;
        wr_beat(4'd1, w[31:24]);
        chk({tag, "_busy"}, bus.ready_mem, 0);
        wr_beat(4'd2, w[23:16]);
        wr_beat(4'd3, w[15:8]);
        wr_beat(4'd4, w[7:0]);
        chk({tag, "_commit0"}, bus.ready_mem, 0);
        step();
        chk({tag, "_commit1"}, bus.ready_mem, 0);
        step();
        chk({tag, "_done"}, bus.ready_mem, 1);
    endtask

    task automatic read_block(input logic [8:0] a, input logic [31:0] exp, input string tag);
        bus.addr_mem = a;
        bus.rd_mem   = 1'b1;
        step();
        bus.rd_mem   = 1'b0;
        chk({tag, "_wait0"}, {bus.ready_mem, bus.rd_valid}, 0);
        step();
        chk({tag, "_wait1"}, {bus.ready_mem, bus.rd_valid}, 0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("%s_valid%0d", tag, k), bus.rd_valid, 1);
            chk($sformatf("%s_byte%0d", tag, k), data_mem, exp[31-8*k -: 8]);
        end
        step();
        chk({tag, "_end"}, {bus.ready_mem, bus.rd_valid}, 2'b10);
    endtask

    initial begin
        bus.addr_mem  = '0;
        bus.rd_mem    = 1'b0;
        bus.wr_mem    = 4'd0;
        bus.wmem_byte = 8'd0;
        step();
        chk("reset_ready", bus.ready_mem, 1);
        chk("reset_rdv", bus.rd_valid, 0);
        chk("reset_err", bus.err, 0);
        reset_n = 1'b1;
        step();

        // Write 0x104 then read it back from an unaligned address in the block
        write_block(9'h104, 32'hAABBCCDD, "wr104");
        chk("wr104_err", bus.err, 0);
        read_block(9'h106, 32'hAABBCCDD, "rd106");

        // Reset in the middle of a burst, during byte1
        bus.addr_mem = 9'h104;
        bus.rd_mem   = 1'b1;
        step();
        bus.rd_mem   = 1'b0;
        step();
        step();
        chk("abort_b0", data_mem, 8'hAA);
        step();
        chk("abort_b1", data_mem, 8'hBB);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_rdv", bus.rd_valid, 0);
        chk("abort_ready", bus.ready_mem, 1);
        step();
        reset_n = 1'b1;
        step();
        read_block(9'h104, 32'hAABBCCDD, "rd_after_abort");

        // Beats separated by idle gaps
        bus.addr_mem = 9'h010;
        wr_beat(4'd1, 8'h11);
        wr_beat(4'd0, 8'h00);
        wr_beat(4'd2, 8'h22);
        wr_beat(4'd0, 8'h00);
        wr_beat(4'd0, 8'h00);
        chk("gap_busy", bus.ready_mem, 0);
        wr_beat(4'd3, 8'h33);
        wr_beat(4'd4, 8'h44);
        chk("gap_c0", bus.ready_mem, 0);
        step();
        chk("gap_c1", bus.ready_mem, 0);
        step();
        chk("gap_done", bus.ready_mem, 1);
        chk("gap_err", bus.err, 0);
        read_block(9'h013, 32'h11223344, "rd010");

        // Out-of-order beat discards the block
        write_block(9'h020, 32'h01020304, "wr020");
        bus.addr_mem = 9'h020;
        wr_beat(4'd1, 8'h55);
        wr_beat(4'd3, 8'h66);
        chk("ooo_err", bus.err, 1);
        chk("ooo_ready", bus.ready_mem, 1);
        read_block(9'h020, 32'h01020304, "rd020");

        // Clear sticky err, then collide a read with a write accept
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        chk("err_cleared", bus.err, 0);
        bus.addr_mem  = 9'h030;
        bus.rd_mem    = 1'b1;
        wr_beat(4'd1, 8'h77);
        bus.rd_mem    = 1'b0;
        chk("coll_err", bus.err, 1);
        chk("coll_rdv0", bus.rd_valid, 0);
        wr_beat(4'd2, 8'h88);
        chk("coll_rdv1", bus.rd_valid, 0);
        wr_beat(4'd3, 8'h99);
        wr_beat(4'd4, 8'hAB);
        chk("coll_rdv2", bus.rd_valid, 0);
        step();
        step();
        chk("coll_done", {bus.ready_mem, bus.rd_valid}, 2'b10);
        read_block(9'h030, 32'h778899AB, "rd030");

        // Top block must not wrap into block 0
        write_block(9'h000, 32'h05060708, "wr000");
        write_block(9'h1FF, 32'hE1E2E3E4, "wr1ff");
        read_block(9'h1FF, 32'hE1E2E3E4, "rd1ff");
        read_block(9'h000, 32'h05060708, "rd000");
        read_block(9'h104, 32'hAABBCCDD, "rd104_final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
